// File: rtl/seq_checker.sv
// seq_checker: checks player button presses against a latched 1..3 symbol sequence
//
// Ports:
//   clk_i          system clock, rising edge
//   rstgame_i      asynchronous active-high reset
//   start_i        one-cycle request to begin checking (accepted only when idle)
//   stage1_i       stage select, length 1 (sampled at start)
//   stage3_i       stage select, length 3, priority over stage1_i (sampled at start)
//   data1_i..3_i   expected symbols 0..2 (sampled at start)
//   button_i       synchronised button levels, bit k pressed = symbol k
//   busy_o         high whenever a check is in progress
//   idx_o          index of the symbol currently expected
//   pass_o         one-cycle pulse: whole sequence matched
//   fail_o         one-cycle pulse: sequence failed
//   fail_code_o    00 none, 01 wrong symbol, 10 multi-press, 11 timeout
module seq_checker #(
    parameter int TIMEOUT = 8
) (
    input  logic       clk_i,
    input  logic       rstgame_i,
    input  logic       start_i,
    input  logic       stage1_i,
    input  logic       stage3_i,
    input  logic [1:0] data1_i,
    input  logic [1:0] data2_i,
    input  logic [1:0] data3_i,
    input  logic [3:0] button_i,
    output logic       busy_o,
    output logic [1:0] idx_o,
    output logic       pass_o,
    output logic       fail_o,
    output logic [1:0] fail_code_o
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_PASS, S_FAIL} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  len_q, len_d;
    logic [1:0]  exp0_q, exp0_d;
    logic [1:0]  exp1_q, exp1_d;
    logic [1:0]  exp2_q, exp2_d;
    logic [1:0]  code_q, code_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [1:0] sym;
    logic [1:0] exp_sel;
    logic       none;
    logic       onehot;
    logic       last;

    assign none    = button_i == 4'b0000;
    // a nonzero value with a single bit set has no bits in common with itself minus one
    assign onehot  = !none && ((button_i & (button_i - 4'd1)) == 4'b0000);
    assign sym     = button_i[3] ? 2'd3 : button_i[2] ? 2'd2 : button_i[1] ? 2'd1 : 2'd0;
    assign exp_sel = (idx_q == 2'd2) ? exp2_q : (idx_q == 2'd1) ? exp1_q : exp0_q;
    assign last    = idx_q == (len_q - 2'd1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        exp0_d  = exp0_q;
        exp1_d  = exp1_q;
        exp2_d  = exp2_q;
        code_d  = code_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ARM;
                    exp0_d  = data1_i;
                    exp1_d  = data2_i;
                    exp2_d  = data3_i;
                    len_d   = stage3_i ? 2'd3 : stage1_i ? 2'd1 : 2'd2;
                    idx_d   = 2'd0;
                    timer_d = '0;
                    code_d  = 2'b00;
                end
            end
            // a full release is required here, so a held button is only counted once
            S_ARM: begin
                if (none) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
            end
            S_WAIT: begin
                if (!none && !onehot) begin
                    state_d = S_FAIL;
                    code_d  = 2'b10;
                end else if (onehot && sym != exp_sel) begin
                    state_d = S_FAIL;
                    code_d  = 2'b01;
                end else if (onehot) begin
                    state_d = last ? S_PASS : S_ARM;
                    idx_d   = last ? idx_q : idx_q + 2'd1;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_FAIL;
                    code_d  = 2'b11;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rstgame_i) begin
        if (rstgame_i) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            len_q   <= 2'd2;
            exp0_q  <= 2'd0;
            exp1_q  <= 2'd0;
            exp2_q  <= 2'd0;
            code_q  <= 2'b00;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            exp0_q  <= exp0_d;
            exp1_q  <= exp1_d;
            exp2_q  <= exp2_d;
            code_q  <= code_d;
            timer_q <= timer_d;
        end
    end

    assign busy_o      = state_q != S_IDLE;
    assign pass_o      = state_q == S_PASS;
    assign fail_o      = state_q == S_FAIL;
    assign idx_o       = idx_q;
    assign fail_code_o = code_q;
endmodule

// File: doc/seq_checker.md
# seq_checker

Downstream consumer of the pattern generator: latches the generated 2-bit symbols (data1..data3) on a start pulse, then watches the four player buttons and checks each press against the expected symbol in order. Reports pass or fail, with a fail reason, to the game controller, which uses the result to advance or restart the stage. Sequence length is set by the stage-select inputs.

## Interface
- TIMEOUT, 8: max clock cycles allowed in WAIT for each press; must be ≥2.
- clk  in  1  system clock; all state changes on its rising edge.
- rstgame  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle request to begin checking; ignored while busy=1.
- stage1  in  1  stage select, sampled at start.
- stage3  in  1  stage select, sampled at start; has priority over stage1.
- data1, data2, data3  in  2 each  expected symbols 0, 1 and 2, sampled at start.
- button  in  4  button levels, already synchronised; bit k pressed = symbol k (bit0→00 … bit3→11).
- busy  out  1  high in every state except IDLE.
- idx  out  2  index of the symbol currently expected (0..2).
- pass  out  1  one-cycle pulse: full sequence matched.
- fail  out  1  one-cycle pulse: sequence failed.
- fail_code  out  2  00 none, 01 wrong symbol, 10 multi-press, 11 timeout; held from the fail pulse until the next accepted start or reset.

## Operation
- Length len at start: stage3=1 → 3; else stage1=1 → 1; else 2.
- States: IDLE, ARM, WAIT, PASS, FAIL.
- IDLE: start=1 → latch data1..3 into exp[0..2], latch len, idx←0, timer←0, fail_code←00, go to ARM.
- ARM: waits for release. button==0000 → WAIT with timer←0. No timeout in ARM.
- WAIT, evaluated each edge in priority order:
  - button not zero and not one-hot → FAIL, fail_code←10.
  - button one-hot, encoded symbol ≠ exp[idx] → FAIL, fail_code←01.
  - symbol = exp[idx] and idx = len−1 → PASS.
  - symbol = exp[idx] and idx < len−1 → idx←idx+1, go to ARM.
  - button=0000 and timer = TIMEOUT−1 → FAIL, fail_code←11.
  - Otherwise, button=0000 → timer←timer+1.
- PASS: pass=1 for this one cycle, then IDLE.
- FAIL: fail=1 for this one cycle, then IDLE.
- A held button counts once, because ARM requires a full release before the next press is evaluated.
- The timer is $clog2(TIMEOUT) bits wide and never wraps. It resets on each entry to WAIT.
- start asserted in any state other than IDLE has no effect. start in the same cycle as PASS or FAIL is also ignored.

## Timing
- Reset (asynchronous): state=IDLE, busy=0, idx=0, pass=0, fail=0, fail_code=00, timer=0, exp=0, len=2.
- Reset asserted mid-sequence aborts the check immediately. No pass or fail pulse is produced.
- start sampled at edge N: busy=1 from edge N (ARM).
- From ARM, with button already 0 at edge N+1: WAIT at N+1.
- Matching final press sampled at edge M → PASS state at M, pass high in cycle M..M+1, busy=0 from edge M+1.
- FAIL follows the same timing as PASS.
- Timeout: with no press, entering WAIT at edge W → FAIL at edge W+TIMEOUT.
- idx updates at the same edge that moves WAIT→ARM.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Pass, len 3: reset, stage3=1, data=01/11/00, start. Then press button 0010, release, 1000, release, 0001. Required: pass pulses once, fail_code=00, idx steps 0→1→2, busy drops the cycle after the pass pulse.
- Wrong symbol: stage1=1, data1=10, start, press 0010. Required: fail pulse one cycle after the press edge, fail_code=01, and fail_code still 01 ten cycles later.
- Multi-press and held button: len 2, data=00/00. Hold 0001 for 5 cycles with no release; required: no advance past idx=1. Release, then press 0011; required: fail_code=10.
- Timeout: TIMEOUT=8, stage1=1, start, button held at 0000. Required: fail exactly 8 cycles after WAIT entry, fail_code=11. Then a new start clears fail_code to 00.
- Reset and start corner cases:
  - rstgame mid-WAIT at idx=1: required: busy=0 and idx=0 immediately (before the next edge), no pulses.
  - start while busy: required: ignored, exp unchanged.
  - stage1=stage3=1: required: len 3.
